main_data_router: RTL

Parametrised bit-serial router between the main-data bit FIFO and the per-(granule, channel) scalefactor parsers and the Huffman decoder. On each side-info valid pulse it drops stale reservoir bits, as located by main_data_begin. It then walks granules and channels in order. For each pair it routes part2 bits to the matching sf parser until that parser signals done, then routes the remaining part2_3_length bits to the Huffman decoder. It supports mono/stereo at run time and flags length and underflow errors.

---
 rtl/main_data_router_pkg.sv | 23 ++
 rtl/main_data_router_bit_down_counter.sv | 33 +++
 rtl/main_data_router.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/main_data_router_pkg.sv
// Shared constants for the main-data router: FSM state codes, default widths
// and the flat (granule, channel) index used by every per-pair vector.
package mp3_dec_pkg;

   localparam int DEF_NUM_GR = 2;
   localparam int DEF_NUM_CH = 2;
   localparam int DEF_LEN_W  = 12;
   localparam int DEF_CNT_W  = 16;
   localparam int DEF_MDB_W  = 9;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_SKIP = 3'd1;
   localparam logic [2:0] ST_LOAD = 3'd2;
   localparam logic [2:0] ST_SF   = 3'd3;
   localparam logic [2:0] ST_HF   = 3'd4;
   localparam logic [2:0] ST_NEXT = 3'd5;

   // Flat index of a (granule, channel) pair: gr*num_ch + ch.
   function automatic int unsigned pair_idx(input logic g, input logic c, input int unsigned num_ch);
      return (g ? num_ch : 32'd0) + (c ? 32'd1 : 32'd0);
   endfunction

endpackage

// File: rtl/main_data_router_bit_down_counter.sv
// Loadable down-counter with zero and one flags; shared by the stale-bit skip
// count and the remaining Huffman bit count.
module bit_down_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         one
);

   logic [W-1:0] count_r;

   // Load has priority; decrement never wraps below zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != {W{1'b0}})) begin
         count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == {W{1'b0}});
   assign one  = (count_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/main_data_router.sv
// Bit-serial router from the main-data FIFO to the per-(gr,ch) scalefactor
// parsers and the Huffman decoder, with reservoir skipping and error flags.
module main_data_router
   import mp3_dec_pkg::*;
#(
   parameter int NUM_GR = DEF_NUM_GR,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int MDB_W  = DEF_MDB_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [CNT_W-1:0]               fifo_sample_count,
   input  logic                           fifo_dout,
   input  logic                           fifo_dout_v,
   output logic                           rea,
   input  logic                           si_valid_in,
   input  logic [MDB_W-1:0]               main_data_begin,
   input  logic [NUM_GR*NUM_CH*LEN_W-1:0] part2_3_length,
   input  logic                           mono,
   input  logic                           sink_ready,
   input  logic [NUM_GR*NUM_CH-1:0]       sf_done,
   output logic                           bit_out,
   output logic [NUM_GR*NUM_CH-1:0]       sf_valid,
   output logic                           hf_valid,
   output logic                           sf_parser_flag,
   output logic                           hf_decoder_flag,
   output logic                           gr,
   output logic                           ch,
   output logic                           granule_done,
   output logic                           frame_done,
   output logic                           underflow_err,
   output logic                           len_err,
   output logic                           si_drop
);

   localparam int NPAIR = NUM_GR * NUM_CH;
   localparam int IDX_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

   logic [2:0]             state_r, state_nx_s;
   logic [NPAIR*LEN_W-1:0] len_r;
   logic                   mono_r, gr_r, ch_r;
   logic [LEN_W-1:0]       p23_r, bitcnt_r, bitcnt_inc_s, rem_s, len_sel_s;
   logic [IDX_W-1:0]       idx_s;
   logic [CNT_W:0]         skip_s;
   logic                   skip_neg_s, rea_s, xfer_s, done_s;
   logic                   last_ch_s, ch_more_s, gr_more_s;
   logic                   cnt_load_s, cnt_dec_s, cnt_zero_s, cnt_one_s;
   logic [CNT_W-1:0]       cnt_val_s;
   logic                   granule_done_r, frame_done_r, underflow_err_r, len_err_r, si_drop_r;

   assign idx_s        = IDX_W'(pair_idx(gr_r, ch_r, NUM_CH));
   assign len_sel_s    = len_r[idx_s*LEN_W +: LEN_W];
   assign skip_s       = {1'b0, fifo_sample_count} - (CNT_W+1)'({main_data_begin, 3'b000});
   assign skip_neg_s   = skip_s[CNT_W];
   assign done_s       = sf_done[idx_s];
   assign xfer_s       = rea_s && fifo_dout_v;
   // The bit arriving with sf_done is counted before the length comparison.
   assign bitcnt_inc_s = (xfer_s && !(&bitcnt_r)) ? bitcnt_r + {{(LEN_W-1){1'b0}}, 1'b1} : bitcnt_r;
   assign rem_s        = (bitcnt_inc_s > p23_r) ? {LEN_W{1'b0}} : p23_r - bitcnt_inc_s;
   assign last_ch_s    = (NUM_CH > 1) && !mono_r;
   assign ch_more_s    = !ch_r && last_ch_s;
   assign gr_more_s    = (NUM_GR > 1) && !gr_r;

   bit_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_s),
      .load_val (cnt_val_s),
      .dec      (cnt_dec_s),
      .zero     (cnt_zero_s),
      .one      (cnt_one_s)
   );

   // FIFO pop request: skipping ignores the sink, routing waits for it.
   always_comb begin
      rea_s = 1'b0;
      case (state_r)
         ST_SKIP: rea_s = fifo_dout_v && !cnt_zero_s;
         ST_SF:   rea_s = fifo_dout_v && sink_ready;
         ST_HF:   rea_s = fifo_dout_v && sink_ready && !cnt_zero_s;
         default: rea_s = 1'b0;
      endcase
   end

   // One-hot scalefactor strobe for the pair currently being parsed.
   always_comb begin
      sf_valid = {NPAIR{1'b0}};
      if (state_r == ST_SF) begin
         sf_valid[idx_s] = xfer_s;
      end else begin
         sf_valid = {NPAIR{1'b0}};
      end
   end

   // Next state and shared counter control.
   always_comb begin
      state_nx_s = state_r;
      cnt_load_s = 1'b0;
      cnt_val_s  = {CNT_W{1'b0}};
      cnt_dec_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (si_valid_in && !skip_neg_s) begin
               state_nx_s = ST_SKIP;
               cnt_load_s = 1'b1;
               cnt_val_s  = skip_s[CNT_W-1:0];
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SKIP: begin
            cnt_dec_s = xfer_s;
            if (cnt_zero_s || (xfer_s && cnt_one_s)) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_SKIP;
            end
         end
         ST_LOAD: begin
            if (len_sel_s == {LEN_W{1'b0}}) begin
               state_nx_s = ST_NEXT;
            end else begin
               state_nx_s = ST_SF;
            end
         end
         ST_SF: begin
            if (done_s) begin
               cnt_load_s = 1'b1;
               cnt_val_s  = CNT_W'(rem_s);
               state_nx_s = (rem_s == {LEN_W{1'b0}}) ? ST_NEXT : ST_HF;
            end else begin
               state_nx_s = ST_SF;
            end
         end
         ST_HF: begin
            cnt_dec_s = xfer_s;
            if (xfer_s && cnt_one_s) begin
               state_nx_s = ST_NEXT;
            end else begin
               state_nx_s = ST_HF;
            end
         end
         ST_NEXT: begin
            if (ch_more_s || gr_more_s) begin
               state_nx_s = ST_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State, latched side info, pair walk, bit count and status flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r         <= ST_IDLE;
         len_r           <= {(NPAIR*LEN_W){1'b0}};
         mono_r          <= 1'b0;
         gr_r            <= 1'b0;
         ch_r            <= 1'b0;
         p23_r           <= {LEN_W{1'b0}};
         bitcnt_r        <= {LEN_W{1'b0}};
         granule_done_r  <= 1'b0;
         frame_done_r    <= 1'b0;
         underflow_err_r <= 1'b0;
         len_err_r       <= 1'b0;
         si_drop_r       <= 1'b0;
      end else begin
         state_r        <= state_nx_s;
         granule_done_r <= (state_r == ST_NEXT);
         frame_done_r   <= ((state_r == ST_NEXT) && !ch_more_s && !gr_more_s) ||
                           ((state_r == ST_IDLE) && si_valid_in && skip_neg_s);
         si_drop_r      <= si_valid_in && (state_r != ST_IDLE);
         case (state_r)
            ST_IDLE: begin
               if (si_valid_in) begin
                  len_r  <= part2_3_length;
                  mono_r <= mono;
                  gr_r   <= 1'b0;
                  ch_r   <= 1'b0;
                  if (skip_neg_s) begin
                     underflow_err_r <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               p23_r    <= len_sel_s;
               bitcnt_r <= {LEN_W{1'b0}};
            end
            ST_SF: begin
               bitcnt_r <= bitcnt_inc_s;
               if (done_s && (bitcnt_inc_s > p23_r)) begin
                  len_err_r <= 1'b1;
               end
            end
            ST_NEXT: begin
               if (ch_more_s) begin
                  ch_r <= 1'b1;
               end else if (gr_more_s) begin
                  ch_r <= 1'b0;
                  gr_r <= 1'b1;
               end else begin
                  ch_r <= 1'b0;
                  gr_r <= 1'b0;
               end
            end
            default: begin
               bitcnt_r <= bitcnt_r;
            end
         endcase
      end
   end

   assign rea             = rea_s;
   assign bit_out         = fifo_dout;
   assign hf_valid        = xfer_s && (state_r == ST_HF);
   assign sf_parser_flag  = (state_r == ST_SF);
   assign hf_decoder_flag = (state_r == ST_HF);
   assign gr              = gr_r;
   assign ch              = ch_r;
   assign granule_done    = granule_done_r;
   assign frame_done      = frame_done_r;
   assign underflow_err   = underflow_err_r;
   assign len_err         = len_err_r;
   assign si_drop         = si_drop_r;

endmodule
